noc_credit_link: RTL and testbench

- Parametrised, multi-channel pipelined router-to-router link for the mesh NoC.
- Retimes the flit bundle (data, dest, is_tail, send) forward and credits backward through NUM_PIPELINE register stages per channel.
- Per channel, monitors link protocol: credit accounting, packet framing, flit/packet statistics, and sticky error flags.
- Sits between a router's output ports and the neighbouring router's input ports, one channel per mesh direction.

---
 rtl/noc_credit_link.sv | 196 +++++++++++++++++++
 tb/tb_noc_credit_link.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_credit_link.sv
// noc_credit_link: multi-channel retiming link between neighbouring mesh routers.
// Flits travel forward and credits travel backward through NUM_PIPELINE register stages.
// Each channel also watches the upstream side for credit, framing and statistics events.
module noc_credit_link #(
  parameter int unsigned NUM_LINKS    = 4,
  parameter int unsigned FLIT_WIDTH   = 32,
  parameter int unsigned DEST_WIDTH   = 6,
  parameter int unsigned NUM_PIPELINE = 1,
  parameter int unsigned LINK_CREDITS = 4,
  parameter int unsigned STAT_WIDTH   = 16
) (
  input  logic                                  clk_noc,
  input  logic                                  rst_n,
  input  logic [NUM_LINKS-1:0][FLIT_WIDTH-1:0]  data_in,
  input  logic [NUM_LINKS-1:0][DEST_WIDTH-1:0]  dest_in,
  input  logic [NUM_LINKS-1:0]                  is_tail_in,
  input  logic [NUM_LINKS-1:0]                  send_in,
  output logic [NUM_LINKS-1:0]                  credit_out,
  output logic [NUM_LINKS-1:0][FLIT_WIDTH-1:0]  data_out,
  output logic [NUM_LINKS-1:0][DEST_WIDTH-1:0]  dest_out,
  output logic [NUM_LINKS-1:0]                  is_tail_out,
  output logic [NUM_LINKS-1:0]                  send_out,
  input  logic [NUM_LINKS-1:0]                  credit_in,
  input  logic                                  clear_stats,
  output logic [NUM_LINKS-1:0]                  err_credit_underflow,
  output logic [NUM_LINKS-1:0]                  err_credit_overflow,
  output logic [NUM_LINKS-1:0]                  err_dest_change,
  output logic [NUM_LINKS-1:0][STAT_WIDTH-1:0]  flit_count,
  output logic [NUM_LINKS-1:0][STAT_WIDTH-1:0]  pkt_count
);

  localparam int unsigned CntW = $clog2(LINK_CREDITS + 1);
  localparam logic [CntW-1:0] MaxCredits = CntW'(LINK_CREDITS);

  typedef enum logic [0:0] {
    StIdle,
    StInPkt
  } frame_state_e;

  for (genvar gl = 0; gl < NUM_LINKS; gl++) begin : g_link

    // ------------------------------------------------------------------
    // Retiming pipeline (forward flit bundle, backward credit)
    // ------------------------------------------------------------------
    if (NUM_PIPELINE == 0) begin : g_wire
      assign send_out[gl]    = send_in[gl];
      assign data_out[gl]    = data_in[gl];
      assign dest_out[gl]    = dest_in[gl];
      assign is_tail_out[gl] = is_tail_in[gl];
      assign credit_out[gl]  = credit_in[gl];
    end else begin : g_pipe
      logic [NUM_PIPELINE-1:0]                 r_send;
      logic [NUM_PIPELINE-1:0]                 r_tail;
      logic [NUM_PIPELINE-1:0]                 r_credit;
      logic [NUM_PIPELINE-1:0][FLIT_WIDTH-1:0] r_data;
      logic [NUM_PIPELINE-1:0][DEST_WIDTH-1:0] r_dest;

      // Shift every stage by one each cycle; reset flushes in-flight flits and credits.
      always_ff @(posedge clk_noc) begin
        if (!rst_n) begin
          r_send   <= '0;
          r_tail   <= '0;
          r_credit <= '0;
          r_data   <= '0;
          r_dest   <= '0;
        end else begin
          r_send[0]   <= send_in[gl];
          r_tail[0]   <= is_tail_in[gl];
          r_credit[0] <= credit_in[gl];
          r_data[0]   <= data_in[gl];
          r_dest[0]   <= dest_in[gl];
          for (int s = 1; s < NUM_PIPELINE; s++) begin
            r_send[s]   <= r_send[s-1];
            r_tail[s]   <= r_tail[s-1];
            r_credit[s] <= r_credit[s-1];
            r_data[s]   <= r_data[s-1];
            r_dest[s]   <= r_dest[s-1];
          end
        end
      end

      assign send_out[gl]    = r_send[NUM_PIPELINE-1];
      assign is_tail_out[gl] = r_tail[NUM_PIPELINE-1];
      assign credit_out[gl]  = r_credit[NUM_PIPELINE-1];
      assign data_out[gl]    = r_data[NUM_PIPELINE-1];
      assign dest_out[gl]    = r_dest[NUM_PIPELINE-1];
    end

    // ------------------------------------------------------------------
    // Credit accounting, seen from the upstream sender's point of view
    // ------------------------------------------------------------------
    logic [CntW-1:0] r_cred_cnt;
    logic [CntW-1:0] w_cred_cnt_nxt;
    logic            w_underflow;
    logic            w_overflow;

    // Next credit count; illegal send/credit events hold the counter and raise a flag.
    always_comb begin
      w_cred_cnt_nxt = r_cred_cnt;
      w_underflow    = 1'b0;
      w_overflow     = 1'b0;
      case ({send_in[gl], credit_out[gl]})
        2'b10: begin
          if (r_cred_cnt == '0) w_underflow = 1'b1;
          else                  w_cred_cnt_nxt = r_cred_cnt - 1'b1;
        end
        2'b01: begin
          if (r_cred_cnt == MaxCredits) w_overflow = 1'b1;
          else                          w_cred_cnt_nxt = r_cred_cnt + 1'b1;
        end
        default: ;
      endcase
    end

    // Credit counter register; unaffected by clear_stats.
    always_ff @(posedge clk_noc) begin
      if (!rst_n) r_cred_cnt <= MaxCredits;
      else        r_cred_cnt <= w_cred_cnt_nxt;
    end

    // ------------------------------------------------------------------
    // Packet framing monitor
    // ------------------------------------------------------------------
    frame_state_e          r_state;
    frame_state_e          w_state_nxt;
    logic [DEST_WIDTH-1:0] r_pkt_dest;
    logic [DEST_WIDTH-1:0] w_pkt_dest_nxt;
    logic                  w_dest_err;

    // Framing next state: head latches dest, tail returns to idle, body dest must match head.
    always_comb begin
      w_state_nxt    = r_state;
      w_pkt_dest_nxt = r_pkt_dest;
      w_dest_err     = 1'b0;
      case (r_state)
        StIdle: begin
          if (send_in[gl] && !is_tail_in[gl]) begin
            w_state_nxt    = StInPkt;
            w_pkt_dest_nxt = dest_in[gl];
          end
        end
        StInPkt: begin
          if (send_in[gl]) begin
            if (dest_in[gl] != r_pkt_dest) w_dest_err = 1'b1;
            if (is_tail_in[gl])            w_state_nxt = StIdle;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end

    // Framing state and latched head dest; unaffected by clear_stats.
    always_ff @(posedge clk_noc) begin
      if (!rst_n) begin
        r_state    <= StIdle;
        r_pkt_dest <= '0;
      end else begin
        r_state    <= w_state_nxt;
        r_pkt_dest <= w_pkt_dest_nxt;
      end
    end

    // ------------------------------------------------------------------
    // Statistics and sticky error flags
    // ------------------------------------------------------------------
    logic [STAT_WIDTH-1:0] r_flit_cnt;
    logic [STAT_WIDTH-1:0] r_pkt_cnt;
    logic                  r_err_uf;
    logic                  r_err_of;
    logic                  r_err_dest;

    // Counters wrap naturally; clear_stats wins over any event in the same cycle.
    always_ff @(posedge clk_noc) begin
      if (!rst_n || clear_stats) begin
        r_flit_cnt <= '0;
        r_pkt_cnt  <= '0;
        r_err_uf   <= 1'b0;
        r_err_of   <= 1'b0;
        r_err_dest <= 1'b0;
      end else begin
        if (send_in[gl])                   r_flit_cnt <= r_flit_cnt + 1'b1;
        if (send_in[gl] && is_tail_in[gl]) r_pkt_cnt  <= r_pkt_cnt + 1'b1;
        if (w_underflow)                   r_err_uf   <= 1'b1;
        if (w_overflow)                    r_err_of   <= 1'b1;
        if (w_dest_err)                    r_err_dest <= 1'b1;
      end
    end

    assign flit_count[gl]           = r_flit_cnt;
    assign pkt_count[gl]            = r_pkt_cnt;
    assign err_credit_underflow[gl] = r_err_uf;
    assign err_credit_overflow[gl]  = r_err_of;
    assign err_dest_change[gl]      = r_err_dest;
  end

endmodule

// File: tb/tb_noc_credit_link.sv
// tb_noc_credit_link: directed checks of the retiming link and its protocol monitor.
// Main DUT uses two pipeline stages and 4-bit statistics; a zero-stage copy checks the wire mode.
module tb_noc_credit_link;

  localparam int unsigned NL = 4;
  localparam int unsigned FW = 32;
  localparam int unsigned DW = 6;
  localparam int unsigned SW = 4;

  logic                   clk_noc;
  logic                   rst_n;
  logic [NL-1:0][FW-1:0]  data_in;
  logic [NL-1:0][DW-1:0]  dest_in;
  logic [NL-1:0]          is_tail_in;
  logic [NL-1:0]          send_in;
  logic [NL-1:0]          credit_in;
  logic                   clear_stats;

  logic [NL-1:0]          credit_out, is_tail_out, send_out;
  logic [NL-1:0][FW-1:0]  data_out;
  logic [NL-1:0][DW-1:0]  dest_out;
  logic [NL-1:0]          err_uf, err_of, err_dc;
  logic [NL-1:0][SW-1:0]  flit_count, pkt_count;

  logic [NL-1:0]          p0_credit_out, p0_is_tail_out, p0_send_out;
  logic [NL-1:0][FW-1:0]  p0_data_out;
  logic [NL-1:0][DW-1:0]  p0_dest_out;
  logic [NL-1:0]          p0_err_uf, p0_err_of, p0_err_dc;
  logic [NL-1:0][SW-1:0]  p0_flit_count, p0_pkt_count;

  int n_cmp = 0;
  int n_mis = 0;
  int n_fwd;

  noc_credit_link #(
    .NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .NUM_PIPELINE(2), .LINK_CREDITS(4), .STAT_WIDTH(SW)
  ) u_dut (
    .clk_noc(clk_noc), .rst_n(rst_n),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out), .data_out(data_out), .dest_out(dest_out),
    .is_tail_out(is_tail_out), .send_out(send_out), .credit_in(credit_in),
    .clear_stats(clear_stats),
    .err_credit_underflow(err_uf), .err_credit_overflow(err_of), .err_dest_change(err_dc),
    .flit_count(flit_count), .pkt_count(pkt_count)
  );

  noc_credit_link #(
    .NUM_LINKS(NL), .FLIT_WIDTH(FW), .DEST_WIDTH(DW),
    .NUM_PIPELINE(0), .LINK_CREDITS(4), .STAT_WIDTH(SW)
  ) u_dut_p0 (
    .clk_noc(clk_noc), .rst_n(rst_n),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(p0_credit_out), .data_out(p0_data_out), .dest_out(p0_dest_out),
    .is_tail_out(p0_is_tail_out), .send_out(p0_send_out), .credit_in(credit_in),
    .clear_stats(clear_stats),
    .err_credit_underflow(p0_err_uf), .err_credit_overflow(p0_err_of),
    .err_dest_change(p0_err_dc),
    .flit_count(p0_flit_count), .pkt_count(p0_pkt_count)
  );

  initial clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic idle_inputs();
    data_in     = '0;
    dest_in     = '0;
    is_tail_in  = '0;
    send_in     = '0;
    credit_in   = '0;
    clear_stats = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();

    // Reset state
    check_eq("rst_send_out",   send_out,   '0);
    check_eq("rst_credit_out", credit_out, '0);
    check_eq("rst_flit_count", flit_count, '0);
    check_eq("rst_err_all",    {err_uf, err_of, err_dc}, '0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_send_out", send_out, '0);

    // 3-flit packet on ch1, dest 5: two-cycle latency, data intact
    do_reset();
    send_in[1] = 1'b1; dest_in[1] = 6'h05; data_in[1] = 32'hA000_0001;
    #1;
    check_eq("p0_send_comb", p0_send_out[1], 1'b1);
    check_eq("p0_data_comb", p0_data_out[1], 32'hA000_0001);
    tick();
    check_eq("ch1_not_yet", send_out[1], 1'b0);
    data_in[1] = 32'hA000_0002;
    tick();
    check_eq("ch1_f0_send", send_out, 4'b0010);
    check_eq("ch1_f0_data", data_out[1], 32'hA000_0001);
    check_eq("ch1_f0_dest", dest_out[1], 6'h05);
    check_eq("ch1_f0_tail", is_tail_out[1], 1'b0);
    data_in[1] = 32'hA000_0003; is_tail_in[1] = 1'b1;
    tick();
    check_eq("ch1_f1_data", data_out[1], 32'hA000_0002);
    idle_inputs();
    tick();
    check_eq("ch1_f2_data", data_out[1], 32'hA000_0003);
    check_eq("ch1_f2_tail", is_tail_out[1], 1'b1);
    tick();
    check_eq("ch1_drained", send_out[1], 1'b0);
    check_eq("ch1_flits", flit_count[1], 4'd3);
    check_eq("ch1_pkts",  pkt_count[1],  4'd1);
    check_eq("ch1_no_err", {err_uf, err_of, err_dc}, '0);

    // Credit pulse on ch2 appears exactly two edges later; counter is full so overflow flags
    credit_in[2] = 1'b1;
    tick();
    credit_in[2] = 1'b0;
    check_eq("cred2_early", credit_out, 4'b0000);
    tick();
    check_eq("cred2_arrive", credit_out, 4'b0100);
    check_eq("cred2_of_pre", err_of[2], 1'b0);
    tick();
    check_eq("cred2_gone", credit_out, 4'b0000);
    check_eq("cred2_of_set", err_of, 4'b0100);

    // 5 sends on ch0 with no credits back: underflow on the 5th, all flits forwarded
    do_reset();
    n_fwd = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 5) begin
        send_in[0] = 1'b1; dest_in[0] = 6'h01;
        data_in[0] = 32'h100 + c; is_tail_in[0] = (c == 4);
      end else begin
        idle_inputs();
      end
      tick();
      n_fwd += int'(send_out[0]);
      if (c == 3) check_eq("uf_after_4", err_uf[0], 1'b0);
      if (c == 4) check_eq("uf_after_5", err_uf[0], 1'b1);
    end
    check_eq("uf_fwd_count", n_fwd, 5);
    for (int c = 0; c < 10; c++) tick();
    check_eq("uf_sticky", err_uf, 4'b0001);
    check_eq("uf_flits", flit_count[0], 4'd5);
    check_eq("uf_pkts",  pkt_count[0],  4'd1);

    // Credit returned to ch3 at full count: overflow, then clear_stats drops it
    do_reset();
    credit_in[3] = 1'b1;
    tick();
    credit_in[3] = 1'b0;
    tick();
    check_eq("of3_pre", err_of[3], 1'b0);
    tick();
    check_eq("of3_set", err_of, 4'b1000);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check_eq("of3_cleared", err_of, 4'b0000);

    // ch0 dest changes mid-packet, ch1 holds its dest
    do_reset();
    send_in = 4'b0011; dest_in[0] = 6'h02; dest_in[1] = 6'h07;
    tick();
    dest_in[0] = 6'h03;
    tick();
    dest_in[0] = 6'h02; is_tail_in = 4'b0011;
    tick();
    idle_inputs();
    check_eq("dc_flags", err_dc, 4'b0001);
    check_eq("dc_pkt0", pkt_count[0], 4'd1);
    check_eq("dc_pkt1", pkt_count[1], 4'd1);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    send_in[0] = 1'b1; is_tail_in[0] = 1'b1; dest_in[0] = 6'h09;
    tick();
    idle_inputs();
    check_eq("dc_idle_after_tail", err_dc, 4'b0000);

    // 17 flits with credits flowing back: 4-bit counter wraps to 1, no credit errors
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_in[0] = 1'b1; credit_in[0] = 1'b1; data_in[0] = 32'h200 + i;
      tick();
    end
    idle_inputs();
    check_eq("wrap_flits", flit_count[0], 4'd1);
    tick();
    tick();
    tick();
    check_eq("wrap_no_cred_err", {err_uf, err_of}, '0);

    // clear_stats in the same cycle as a send: not counted
    send_in[0] = 1'b1; clear_stats = 1'b1;
    tick();
    idle_inputs();
    check_eq("clr_wins", flit_count[0], 4'd0);
    send_in[0] = 1'b1;
    tick();
    idle_inputs();
    check_eq("count_resumes", flit_count[0], 4'd1);

    // Reset mid-packet: everything returns to zero and framing restarts from idle
    send_in[0] = 1'b1; dest_in[0] = 6'h04; data_in[0] = 32'hDEAD_0001;
    tick();
    data_in[0] = 32'hDEAD_0002;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_send",   send_out,    '0);
    check_eq("mid_rst_tail",   is_tail_out, '0);
    check_eq("mid_rst_credit", credit_out,  '0);
    check_eq("mid_rst_data",   |data_out,   1'b0);
    check_eq("mid_rst_dest",   |dest_out,   1'b0);
    check_eq("mid_rst_stats",  {flit_count, pkt_count}, '0);
    check_eq("mid_rst_errs",   {err_uf, err_of, err_dc}, '0);
    rst_n = 1'b1;
    tick();
    check_eq("post_mid_rst_send", send_out, '0);
    send_in[0] = 1'b1; is_tail_in[0] = 1'b1; dest_in[0] = 6'h08;
    tick();
    idle_inputs();
    check_eq("mid_rst_fsm_idle", err_dc, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
